// File: rtl/uart_pkg.sv
// Shared UART definitions: frame states, frame-size constants and the bit-period helper.
package uart_pkg;

    localparam int unsigned DATA_BITS     = 8;
    localparam int unsigned FRAME_PAYLOAD = 9;
    localparam int unsigned BITS_SENT_W   = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    function automatic int unsigned clks_per_bit(input int unsigned clock_freq,
                                                 input int unsigned baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
module uart_baud_counter #(
    parameter int unsigned CLKS_PER_BIT = 5208
) (
    input  logic clk,
    input  logic nRst,
    input  logic i_restart,
    output logic o_bit_done_c
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_count;
    logic             w_terminal;

    assign w_terminal   = (r_count == LAST_CNT);
    assign o_bit_done_c = !i_restart && w_terminal;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_count <= '0;
        end else if (i_restart || w_terminal) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// 8E1 UART transmitter with a one-deep holding register for back-to-back frames.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned CLOCK_FREQ = 50000000
) (
    input  logic                   clk,
    input  logic                   nRst,
    input  logic                   enable,
    input  logic [DATA_BITS-1:0]   data_in,
    input  logic                   data_valid,
    output logic                   tx_ready,
    output logic                   Tx,
    output logic                   sending,
    output logic [BITS_SENT_W-1:0] bits_sent
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ, BAUD_RATE);

    uart_state_e            r_state;
    uart_state_e            w_state_next;
    logic [DATA_BITS-1:0]   r_hold;
    logic                   r_hold_full;
    logic                   w_hold_full_next;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]   w_shift_next;
    logic                   r_parity;
    logic                   w_parity_next;
    logic [BITS_SENT_W-1:0] r_bits_sent;
    logic [BITS_SENT_W-1:0] w_bits_next;
    logic                   r_tx;
    logic                   w_tx_next;
    logic                   r_sending;
    logic                   w_accept;
    logic                   w_load;
    logic                   w_restart;
    logic                   w_bit_done;

    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk         (clk),
        .nRst        (nRst),
        .i_restart   (w_restart),
        .o_bit_done_c(w_bit_done)
    );

    // Timer is held at zero while idle so START always gets a full bit period.
    assign w_restart = (r_state == IDLE);

    assign tx_ready  = !r_hold_full;
    assign Tx        = r_tx;
    assign sending   = r_sending;
    assign bits_sent = r_bits_sent;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_shift_next  = r_shift;
        w_parity_next = r_parity;
        w_bits_next   = r_bits_sent;
        w_load        = 1'b0;
        w_accept      = data_valid && !r_hold_full && enable;
        w_tx_next     = 1'b1;

        case (r_state)
            IDLE: begin
                w_load = r_hold_full && enable;
            end
            START: begin
                if (w_bit_done) begin
                    w_state_next = DATA;
                end
            end
            DATA: begin
                if (w_bit_done) begin
                    w_shift_next = r_shift >> 1;
                    w_bits_next  = r_bits_sent + BITS_SENT_W'(1);
                    if (r_bits_sent == BITS_SENT_W'(DATA_BITS - 1)) begin
                        w_state_next = PARITY;
                    end
                end
            end
            PARITY: begin
                if (w_bit_done) begin
                    w_bits_next  = BITS_SENT_W'(FRAME_PAYLOAD);
                    w_state_next = STOP;
                end
            end
            STOP: begin
                if (w_bit_done) begin
                    w_load       = r_hold_full && enable;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        if (w_load) begin
            w_state_next  = START;
            w_shift_next  = r_hold;
            w_parity_next = ^r_hold;
            w_bits_next   = '0;
        end

        w_hold_full_next = r_hold_full;
        if (w_accept) begin
            w_hold_full_next = 1'b1;
        end else if (w_load) begin
            w_hold_full_next = 1'b0;
        end

        // Line level is registered from the state being entered.
        case (w_state_next)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_shift_next[0];
            PARITY:  w_tx_next = w_parity_next;
            default: w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_shift     <= '0;
            r_parity    <= 1'b0;
            r_bits_sent <= '0;
            r_tx        <= 1'b1;
            r_sending   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_hold <= data_in;
            end
            r_hold_full <= w_hold_full_next;
            r_shift     <= w_shift_next;
            r_parity    <= w_parity_next;
            r_bits_sent <= w_bits_next;
            r_tx        <= w_tx_next;
            r_sending   <= (w_state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: frame-timeline model plus a mid-bit line decoder.
module tb_uart_transmitter;

    localparam int unsigned CLK_HZ = 200;
    localparam int unsigned BAUD   = 15;
    localparam int unsigned CPB    = CLK_HZ / BAUD;
    localparam int unsigned FRAME  = 11 * CPB;

    logic       clk        = 1'b0;
    logic       nRst       = 1'b0;
    logic       enable     = 1'b0;
    logic [7:0] data_in    = 8'h00;
    logic       data_valid = 1'b0;
    logic       tx_ready;
    logic       Tx;
    logic       sending;
    logic [3:0] bits_sent;

    uart_transmitter #(
        .BAUD_RATE (BAUD),
        .CLOCK_FREQ(CLK_HZ)
    ) dut (
        .clk       (clk),
        .nRst      (nRst),
        .enable    (enable),
        .data_in   (data_in),
        .data_valid(data_valid),
        .tx_ready  (tx_ready),
        .Tx        (Tx),
        .sending   (sending),
        .bits_sent (bits_sent)
    );

    always #5 clk = ~clk;

    // Reference: a frame is a timeline of 11 bit slots starting at the load edge.
    int         m_cyc;
    int         m_fstart;
    logic       m_active;
    logic       m_hfull;
    logic [7:0] m_hold;
    logic [7:0] m_fbyte;
    int         m_bits_idle;
    logic [7:0] m_sent_q[$];

    always @(posedge clk or negedge nRst) begin : model
        int   c;
        logic frame_end;
        logic load;
        if (!nRst) begin
            m_cyc       <= 0;
            m_fstart    <= 0;
            m_active    <= 1'b0;
            m_hfull     <= 1'b0;
            m_hold      <= 8'h00;
            m_fbyte     <= 8'h00;
            m_bits_idle <= 0;
            m_sent_q.delete();
        end else begin
            c         = m_cyc + 1;
            frame_end = m_active && ((c - m_fstart) == int'(FRAME));
            load      = (!m_active || frame_end) && m_hfull && enable;
            m_cyc <= c;
            if (load) begin
                m_fstart <= c;
                m_fbyte  <= m_hold;
                m_active <= 1'b1;
                m_sent_q.push_back(m_hold);
            end else if (frame_end) begin
                m_active    <= 1'b0;
                m_bits_idle <= 9;
            end
            if (data_valid && !m_hfull && enable) begin
                m_hfull <= 1'b1;
                m_hold  <= data_in;
            end else if (load) begin
                m_hfull <= 1'b0;
            end
        end
    end

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic        dec_busy = 1'b0;
    logic        dec_prev = 1'b1;
    int          dec_t    = 0;
    logic [10:0] dec_bits = '0;
    logic [10:0] dec_last = '0;
    logic [7:0]  dec_q[$];
    int          fall_q[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic compare_cycle();
        int          k;
        logic [10:0] frame;
        int          etx;
        int          esend;
        int          ebits;
        if (m_active) begin
            k     = (m_cyc - m_fstart) / int'(CPB);
            frame = {1'b1, ^m_fbyte, m_fbyte, 1'b0};
            etx   = int'(frame[k]);
            esend = 1;
            ebits = (k == 0) ? 0 : k - 1;
        end else begin
            etx   = 1;
            esend = 0;
            ebits = m_bits_idle;
        end
        chk("tx", int'(Tx), etx);
        chk("tx_ready", int'(tx_ready), int'(!m_hfull));
        chk("sending", int'(sending), esend);
        chk("bits_sent", int'(bits_sent), ebits);
    endtask

    // Independent line decoder: samples each bit at its middle.
    task automatic decode_cycle();
        int idx;
        if (!dec_busy) begin
            if (dec_prev && !Tx) begin
                dec_busy = 1'b1;
                dec_t    = 0;
                fall_q.push_back(cyc);
            end
        end else begin
            dec_t++;
        end
        if (dec_busy && (dec_t % int'(CPB)) == int'(CPB / 2)) begin
            idx = dec_t / int'(CPB);
            dec_bits[idx] = Tx;
            if (idx == 10) begin
                dec_busy = 1'b0;
                dec_last = dec_bits;
                chk("start bit", int'(dec_bits[0]), 0);
                chk("stop bit", int'(dec_bits[10]), 1);
                chk("parity bit", int'(dec_bits[9]), int'(^dec_bits[8:1]));
                dec_q.push_back(dec_bits[8:1]);
            end
        end
        dec_prev = Tx;
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (nRst) begin
            compare_cycle();
            decode_cycle();
        end else begin
            dec_busy = 1'b0;
            dec_prev = 1'b1;
        end
    endtask

    task automatic clear_bench();
        dec_q.delete();
        fall_q.delete();
        dec_busy = 1'b0;
        dec_prev = 1'b1;
    endtask

    task automatic do_reset();
        nRst = 1'b0;
        tick();
        tick();
        nRst = 1'b1;
        clear_bench();
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        while (!tx_ready && n < 2 * int'(FRAME)) begin
            tick();
            n++;
        end
        chk("ready wait in budget", int'(n < 2 * int'(FRAME)), 1);
        data_in    = b;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sending || !tx_ready) && n < 4 * int'(FRAME)) begin
            tick();
            n++;
        end
        chk("idle wait in budget", int'(n < 4 * int'(FRAME)), 1);
        repeat (3) tick();
    endtask

    task automatic check_bytes();
        chk("frames decoded", dec_q.size(), m_sent_q.size());
        for (int i = 0; i < dec_q.size() && i < m_sent_q.size(); i++) begin
            chk("decoded byte", int'(dec_q[i]), int'(m_sent_q[i]));
        end
    endtask

    initial begin
        int          acc_cyc;
        int          n;
        logic [7:0]  par_bytes[4];
        int          par_exp[4];

        // Power-on reset and quiet idle line.
        do_reset();
        chk("reset Tx", int'(Tx), 1);
        chk("reset tx_ready", int'(tx_ready), 1);
        chk("reset sending", int'(sending), 0);
        chk("reset bits_sent", int'(bits_sent), 0);
        enable = 1'b1;
        repeat (300) tick();
        chk("idle Tx falls", fall_q.size(), 0);

        // 0xA5 frame, first-bit latency and final bit count.
        send(8'hA5);
        acc_cyc = cyc;
        wait_idle();
        chk("A5 frames", dec_q.size(), 1);
        if (fall_q.size() > 0) chk("start latency", fall_q[0] - acc_cyc, 1);
        chk("A5 line bits", int'(dec_last), 11'h54A);
        if (dec_q.size() > 0) chk("A5 byte", int'(dec_q[0]), 8'hA5);
        chk("bits_sent after frame", int'(bits_sent), 9);
        check_bytes();

        // Parity of corner bytes.
        par_bytes = '{8'h00, 8'h01, 8'hFF, 8'h7F};
        par_exp   = '{0, 1, 0, 1};
        for (int i = 0; i < 4; i++) begin
            send(par_bytes[i]);
            wait_idle();
            chk("parity literal", int'(dec_last[9]), par_exp[i]);
        end
        check_bytes();

        // Back-to-back frames; a third offer while full must be ignored.
        do_reset();
        send(8'h3C);
        send(8'hC3);
        data_in    = 8'h99;
        data_valid = 1'b1;
        chk("ready low while held", int'(tx_ready), 0);
        repeat (20) tick();
        data_valid = 1'b0;
        wait_idle();
        chk("b2b frames", dec_q.size(), 2);
        if (fall_q.size() >= 2) chk("b2b spacing", fall_q[1] - fall_q[0], 143);
        if (dec_q.size() >= 2) begin
            chk("b2b first", int'(dec_q[0]), 8'h3C);
            chk("b2b second", int'(dec_q[1]), 8'hC3);
        end
        check_bytes();

        // Enable gating.
        do_reset();
        enable     = 1'b0;
        data_in    = 8'h11;
        data_valid = 1'b1;
        repeat (3) tick();
        data_valid = 1'b0;
        chk("no accept when disabled", int'(tx_ready), 1);
        enable     = 1'b1;
        data_in    = 8'h55;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        enable     = 1'b0;
        repeat (30) tick();
        chk("gated tx_ready", int'(tx_ready), 0);
        chk("gated sending", int'(sending), 0);
        chk("gated Tx", int'(Tx), 1);
        enable = 1'b1;
        tick();
        chk("start after enable", int'(Tx), 0);
        wait_idle();
        chk("gated frames", dec_q.size(), 1);
        if (dec_q.size() > 0) chk("gated byte", int'(dec_q[0]), 8'h55);

        // Reset in the middle of data bit 4.
        do_reset();
        send(8'hA5);
        n = 0;
        while (bits_sent != 4'd4 && n < int'(FRAME)) begin
            tick();
            n++;
        end
        chk("reach bit 4", int'(n < int'(FRAME)), 1);
        repeat (CPB / 2) tick();
        chk("Tx low before reset", int'(Tx), 0);
        nRst = 1'b0;
        #1;
        chk("async reset Tx", int'(Tx), 1);
        chk("async reset sending", int'(sending), 0);
        chk("async reset tx_ready", int'(tx_ready), 1);
        tick();
        tick();
        nRst = 1'b1;
        clear_bench();
        repeat (50) tick();
        chk("no frame after reset", fall_q.size(), 0);
        send(8'h3C);
        wait_idle();
        chk("post-reset frames", dec_q.size(), 1);
        if (dec_q.size() > 0) chk("post-reset byte", int'(dec_q[0]), 8'h3C);

        // Random traffic with enable toggling.
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            tick();
            data_valid = ($urandom_range(0, 7) == 0);
            data_in    = 8'($urandom());
            if ($urandom_range(0, 99) == 0) enable = !enable;
        end
        data_valid = 1'b0;
        enable     = 1'b1;
        wait_idle();
        check_bytes();
        chk("random traffic sent frames", int'(m_sent_q.size() > 10), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
